axil_bram_slave: RTL

- AXI4-Lite responder (slave) backed by an inferred single-clock block RAM.
- Attaches to one PS master port of the system block, e.g. M00_AXI, through its AXI-Lite interconnect.
- The PS writes and reads words over AXI-Lite. PL logic reads the same memory through an independent native read port.

---
 rtl/axil_bram_slave.sv | 257 +++++++++++++++++++++++++
 1 files changed

// File: rtl/axil_bram_slave.sv
// axil_bram_slave
// AXI4-Lite responder backed by a single-clock, read-first block RAM of
// DEPTH 32-bit words, plus an independent registered read port for PL logic.
//
// Ports:
//   axi_clock, axi_resetn       clock and asynchronous active-low reset
//   S_AXI_aw*  / S_AXI_w*       write address / write data channels
//   S_AXI_b*                    write response (OKAY 00, SLVERR 10)
//   S_AXI_ar*  / S_AXI_r*       read address / read data channels
//   pl_rd_en, pl_rd_addr        PL read strobe and word index
//   pl_rd_data                  PL read data, one cycle after pl_rd_en
//
// Word index is addr[ADDR_W+1:2]; indices >= DEPTH answer SLVERR, never
// write the memory and read back as zero. Memory contents survive reset.
`timescale 1ns/1ps

module axil_bram_slave #(
    parameter int unsigned DEPTH     = 1024,
    parameter int unsigned ADDR_W    = 10,
    parameter bit          INIT_ZERO = 1'b1
) (
    input  logic              axi_clock,
    input  logic              axi_resetn,

    input  logic [31:0]       S_AXI_awaddr,
    input  logic [2:0]        S_AXI_awprot,
    input  logic              S_AXI_awvalid,
    output logic              S_AXI_awready,

    input  logic [31:0]       S_AXI_wdata,
    input  logic [3:0]        S_AXI_wstrb,
    input  logic              S_AXI_wvalid,
    output logic              S_AXI_wready,

    output logic [1:0]        S_AXI_bresp,
    output logic              S_AXI_bvalid,
    input  logic              S_AXI_bready,

    input  logic [31:0]       S_AXI_araddr,
    input  logic [2:0]        S_AXI_arprot,
    input  logic              S_AXI_arvalid,
    output logic              S_AXI_arready,

    output logic [31:0]       S_AXI_rdata,
    output logic [1:0]        S_AXI_rresp,
    output logic              S_AXI_rvalid,
    input  logic              S_AXI_rready,

    input  logic              pl_rd_en,
    input  logic [ADDR_W-1:0] pl_rd_addr,
    output logic [31:0]       pl_rd_data
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        W_IDLE,
        W_RESP
    } w_state_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_MEM,
        R_DATA
    } r_state_t;

    // Contents are set at configuration only; no reset path touches them.
    logic [31:0] mem [DEPTH] = '{default: (INIT_ZERO ? 32'h0000_0000 : 32'hxxxx_xxxx)};

    // ------------------------------------------------------------------
    // Write channel
    // ------------------------------------------------------------------
    w_state_t          w_state, w_state_nxt;
    logic              aw_done, w_done;
    logic [ADDR_W-1:0] aw_idx;
    logic [31:0]       wdata_q;
    logic [3:0]        wstrb_q;
    logic              aw_hs, w_hs, b_hs;
    logic              w_commit;
    logic              aw_in_range;

    assign aw_hs       = S_AXI_awvalid && S_AXI_awready;
    assign w_hs        = S_AXI_wvalid  && S_AXI_wready;
    assign b_hs        = S_AXI_bvalid  && S_AXI_bready;
    // Commit happens on the edge after both halves have been captured.
    assign w_commit    = (w_state == W_IDLE) && aw_done && w_done;
    assign aw_in_range = 32'(aw_idx) < DEPTH;

    always_ff @(posedge axi_clock or negedge axi_resetn) begin
        if (!axi_resetn) begin
            w_state <= W_IDLE;
        end else begin
            w_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = w_state;
        case (w_state)
            W_IDLE:  if (w_commit) w_state_nxt = W_RESP;
            W_RESP:  if (b_hs)     w_state_nxt = W_IDLE;
            default: w_state_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge axi_clock or negedge axi_resetn) begin
        if (!axi_resetn) begin
            S_AXI_awready <= 1'b0;
            S_AXI_wready  <= 1'b0;
            S_AXI_bvalid  <= 1'b0;
            S_AXI_bresp   <= RESP_OKAY;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
            aw_idx        <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    // Ready comes up on the first edge after reset and
                    // stays up until that channel's beat is captured.
                    if (aw_hs) begin
                        aw_done       <= 1'b1;
                        S_AXI_awready <= 1'b0;
                        aw_idx        <= S_AXI_awaddr[ADDR_W+1:2];
                    end else if (!aw_done) begin
                        S_AXI_awready <= 1'b1;
                    end

                    if (w_hs) begin
                        w_done       <= 1'b1;
                        S_AXI_wready <= 1'b0;
                        wdata_q      <= S_AXI_wdata;
                        wstrb_q      <= S_AXI_wstrb;
                    end else if (!w_done) begin
                        S_AXI_wready <= 1'b1;
                    end

                    if (w_commit) begin
                        S_AXI_bvalid <= 1'b1;
                        S_AXI_bresp  <= aw_in_range ? RESP_OKAY : RESP_SLVERR;
                    end
                end
                W_RESP: begin
                    if (b_hs) begin
                        S_AXI_bvalid  <= 1'b0;
                        S_AXI_bresp   <= RESP_OKAY;
                        S_AXI_awready <= 1'b1;
                        S_AXI_wready  <= 1'b1;
                        aw_done       <= 1'b0;
                        w_done        <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Byte-enabled memory write; reads elsewhere see the pre-write word
    // on the commit edge (read-first).
    always_ff @(posedge axi_clock) begin
        if (w_commit && aw_in_range) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (wstrb_q[b]) begin
                    mem[aw_idx][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read channel
    // ------------------------------------------------------------------
    r_state_t          r_state, r_state_nxt;
    logic [ADDR_W-1:0] ar_idx;
    logic              ar_hs, r_hs;
    logic              ar_in_range;

    assign ar_hs       = S_AXI_arvalid && S_AXI_arready;
    assign r_hs        = S_AXI_rvalid  && S_AXI_rready;
    assign ar_in_range = 32'(ar_idx) < DEPTH;

    always_ff @(posedge axi_clock or negedge axi_resetn) begin
        if (!axi_resetn) begin
            r_state <= R_IDLE;
        end else begin
            r_state <= r_state_nxt;
        end
    end

    always_comb begin
        r_state_nxt = r_state;
        case (r_state)
            R_IDLE:  if (ar_hs) r_state_nxt = R_MEM;
            R_MEM:   r_state_nxt = R_DATA;
            R_DATA:  if (r_hs)  r_state_nxt = R_IDLE;
            default: r_state_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge axi_clock or negedge axi_resetn) begin
        if (!axi_resetn) begin
            S_AXI_arready <= 1'b0;
            S_AXI_rvalid  <= 1'b0;
            S_AXI_rdata   <= '0;
            S_AXI_rresp   <= RESP_OKAY;
            ar_idx        <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (ar_hs) begin
                        S_AXI_arready <= 1'b0;
                        ar_idx        <= S_AXI_araddr[ADDR_W+1:2];
                    end else begin
                        S_AXI_arready <= 1'b1;
                    end
                end
                R_MEM: begin
                    S_AXI_rvalid <= 1'b1;
                    S_AXI_rdata  <= ar_in_range ? mem[ar_idx] : '0;
                    S_AXI_rresp  <= ar_in_range ? RESP_OKAY : RESP_SLVERR;
                end
                R_DATA: begin
                    if (r_hs) begin
                        S_AXI_rvalid  <= 1'b0;
                        S_AXI_rresp   <= RESP_OKAY;
                        S_AXI_arready <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // PL read port
    // ------------------------------------------------------------------
    logic pl_in_range;

    assign pl_in_range = 32'(pl_rd_addr) < DEPTH;

    always_ff @(posedge axi_clock or negedge axi_resetn) begin
        if (!axi_resetn) begin
            pl_rd_data <= '0;
        end else if (pl_rd_en) begin
            pl_rd_data <= pl_in_range ? mem[pl_rd_addr] : '0;
        end
    end

    // Protection bits and the non-index address bits carry no meaning here.
    logic unused_ok;
    assign unused_ok = ^{S_AXI_awprot, S_AXI_arprot,
                         S_AXI_awaddr[31:ADDR_W+2], S_AXI_awaddr[1:0],
                         S_AXI_araddr[31:ADDR_W+2], S_AXI_araddr[1:0]};

endmodule
